uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Provides the frame state encoding and the baud-timing derivations.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per serial bit period.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Clocks from the start-bit edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-low reset; both flops load RST_VAL
//   d   - asynchronous input
//   q   - synchronised output (second stage)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing (start, DATA_WIDTH data bits LSB first,
// one stop bit), line idles high. Samples each bit at its mid-point.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   i_rx        - serial input from pin (asynchronous, idle high)
//   o_rxdata    - last correctly framed word, bit 0 = first data bit
//   o_rx_valid  - one-cycle strobe, o_rxdata updated this cycle
//   o_frame_err - one-cycle strobe, stop bit sampled low
//   o_busy      - high from start-bit detection until back in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_rxdata,
  output logic                  o_rx_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic rx_s;

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rxdata_d;
  logic                  valid_d, ferr_d, busy_d;
  // Cleared by a framing error; a new start is only accepted once the line
  // has been seen high again, so a stuck-low line yields a single error.
  logic                  armed_q, armed_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (i_rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b1;
      o_rxdata    <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      o_rxdata    <= rxdata_d;
      o_rx_valid  <= valid_d;
      o_frame_err <= ferr_d;
      o_busy      <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_ONE;
    bit_d    = bit_q;
    shift_d  = shift_q;
    armed_d  = armed_q | rx_s;
    rxdata_d = o_rxdata;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    busy_d   = o_busy;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s && armed_q) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rx_s) begin
            rxdata_d = shift_q;
            valid_d  = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DW       = 8;
  localparam int unsigned C        = CLK_FREQ / BAUD;  // 16
  localparam int unsigned H        = C / 2;            // 8
  localparam int unsigned LAT_MIN  = 2 + H + (DW + 1) * C;
  localparam int unsigned LAT_MAX  = LAT_MIN + 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rx;
  logic [DW-1:0] o_rxdata;
  logic          o_rx_valid;
  logic          o_frame_err;
  logic          o_busy;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_RATE (BAUD),
    .DATA_WIDTH(DW),
    .CLK_FREQ  (CLK_FREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .o_rxdata   (o_rxdata),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe monitor, owned by this block only.
  int         valid_n = 0;
  int         ferr_n  = 0;
  int         both_n  = 0;
  int         busy_n  = 0;
  logic [7:0] rx_log [0:63];

  always @(negedge clk) begin
    if (o_rx_valid) begin
      if (valid_n < 64) rx_log[valid_n] = o_rxdata;
      valid_n++;
    end
    if (o_frame_err) ferr_n++;
    if (o_rx_valid && o_frame_err) both_n++;
    if (o_busy) busy_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; leaves the line at the stop level on return.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    i_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < int'(DW); i++) begin
      i_rx = data[i];
      repeat (C) @(negedge clk);
    end
    i_rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0, f0, b0, bz0;
  int lat, busy_low;
  bit seen;
  logic [7:0] lb [0:3];

  initial begin
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;
    rst  = 1'b0;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rxdata", 32'(o_rxdata), 32'h00);
    check("reset_valid", 32'(o_rx_valid), 0);
    check("reset_ferr", 32'(o_frame_err), 0);
    check("reset_busy", 32'(o_busy), 0);
    rst = 1'b1;
    idle(4);

    // Frame 0xA5 with latency and busy tracking
    v0 = valid_n; f0 = ferr_n; b0 = both_n;
    lat = 0; busy_low = 0; seen = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!seen && lat < int'(20 * C)) begin
          @(posedge clk);
          lat++;
          #1;
          if (o_rx_valid) seen = 1;
          else if (lat >= 3 && !o_busy) busy_low++;
        end
      end
    join
    idle(2 * C);
    check("a5_strobe_seen", 32'(seen), 1);
    check("a5_latency_window", 32'(lat >= int'(LAT_MIN) && lat <= int'(LAT_MAX)), 1);
    check("a5_busy_held", 32'(busy_low), 0);
    check("a5_valid_count", 32'(valid_n - v0), 1);
    check("a5_data", 32'(rx_log[v0]), 32'hA5);
    check("a5_no_ferr", 32'(ferr_n - f0), 0);
    check("a5_busy_after", 32'(o_busy), 0);

    // Short low glitch on an idle line
    v0 = valid_n; f0 = ferr_n; bz0 = busy_n;
    i_rx = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(2 * C);
    check("glitch_busy_cycles", 32'(busy_n - bz0), H);
    check("glitch_no_valid", 32'(valid_n - v0), 0);
    check("glitch_no_ferr", 32'(ferr_n - f0), 0);
    check("glitch_rxdata", 32'(o_rxdata), 32'hA5);

    // Framing error, line stuck low for three more bit times
    v0 = valid_n; f0 = ferr_n;
    send_frame(8'h3C, 1'b0);
    repeat (3 * C) @(negedge clk);
    idle(2 * C);
    check("ferr_count", 32'(ferr_n - f0), 1);
    check("ferr_no_valid", 32'(valid_n - v0), 0);
    check("ferr_rxdata_kept", 32'(o_rxdata), 32'hA5);
    check("ferr_busy_after", 32'(o_busy), 0);

    v0 = valid_n;
    send_frame(8'h5A, 1'b1);
    idle(2 * C);
    check("after_ferr_count", 32'(valid_n - v0), 1);
    check("after_ferr_data", 32'(rx_log[v0]), 32'h5A);

    // Back-to-back frames, no idle gap
    v0 = valid_n; f0 = ferr_n;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * C);
    check("b2b_count", 32'(valid_n - v0), 2);
    check("b2b_data0", 32'(rx_log[v0]), 32'h00);
    check("b2b_data1", 32'(rx_log[v0 + 1]), 32'hFF);
    check("b2b_no_ferr", 32'(ferr_n - f0), 0);

    // Reset during data bit 4 of 0x81
    v0 = valid_n; f0 = ferr_n;
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (5 * C + H) @(negedge clk);
        check("pre_reset_busy", 32'(o_busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_rxdata", 32'(o_rxdata), 32'h00);
        check("midrst_busy", 32'(o_busy), 0);
        check("midrst_valid", 32'(o_rx_valid), 0);
      end
    join
    i_rx = 1'b1;
    rst  = 1'b1;
    idle(2 * C);
    check("midrst_no_strobe", 32'((valid_n - v0) + (ferr_n - f0)), 0);
    v0 = valid_n;
    send_frame(8'h81, 1'b1);
    idle(2 * C);
    check("post_rst_count", 32'(valid_n - v0), 1);
    check("post_rst_data", 32'(rx_log[v0]), 32'h81);

    // Transmitter-style stream with one idle bit between frames
    v0 = valid_n; f0 = ferr_n;
    for (int k = 0; k < 4; k++) begin
      send_frame(lb[k], 1'b1);
      idle(C);
    end
    idle(2 * C);
    check("loop_count", 32'(valid_n - v0), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("loop_data%0d", k), 32'(rx_log[v0 + k]), 32'(lb[k]));
    end
    check("loop_no_ferr", 32'(ferr_n - f0), 0);
    check("never_both_strobes", 32'(both_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
